truth_table_capture: RTL and testbench
======================================

TRUTH_TABLE_CAPTURE -- requirements
Module: truth_table_capture

Interface
REQ-001 The block SHALL have parameter SAMPLE_LAT, default 0, giving the cycles from x driven to the f_in sample (0 = combinational function under test).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1, request to begin one sweep; sampled only in IDLE.
REQ-005 The block SHALL have port expected, input, 128, reference truth table compared at end of sweep.
REQ-006 The block SHALL have port x, output, 7, registered input vector driven to the 7-input function (x[0]=x0 ... x[6]=x6).
REQ-007 The block SHALL have port f_in, input, 1, the function output for the vector driven SAMPLE_LAT cycles earlier.
REQ-008 The block SHALL have port busy, output, 1, high from the cycle after start is accepted until done.
REQ-009 The block SHALL have port done, output, 1, one-cycle pulse when tt and match are valid.
REQ-010 The block SHALL have port tt, output, 128, captured truth table; tt[i] = f at x=i, so hex MSB-first reads as the 32-digit classification code.
REQ-011 The block SHALL have port match, output, 1, tt == expected, valid from done until the next accepted start.

Function
REQ-012 States SHALL be IDLE, SWEEP, DRAIN, FIN; IDLE->SWEEP on start, SWEEP->DRAIN after x=127 is driven, DRAIN->FIN after the last sample, FIN->IDLE unconditionally.
REQ-013 With start accepted in cycle 0, x SHALL equal k in cycle k+1 for k=0..127; x SHALL hold 0 outside SWEEP.
REQ-014 Index k SHALL be sampled from f_in in cycle k+1+SAMPLE_LAT via a SAMPLE_LAT-deep valid/index delay line; SAMPLE_LAT=0 bypasses the delay line.
REQ-015 DRAIN SHALL last exactly SAMPLE_LAT cycles (zero cycles when SAMPLE_LAT=0).
REQ-016 done SHALL pulse in cycle 129+SAMPLE_LAT; match SHALL be registered in that same cycle from the final tt.
REQ-017 tt SHALL be cleared to 0 when start is accepted and SHALL hold its final value from done until the next accepted start.
REQ-018 start while busy or in FIN SHALL be ignored; start in IDLE in the cycle after done SHALL be accepted.
REQ-019 The sweep counter SHALL be 8 bits wide so terminal detection (127) never wraps into a second pass.
REQ-020 f_in SHALL be treated as unknown and ignored outside sample cycles.

Reset
REQ-021 rst SHALL force IDLE, x=0, busy=0, done=0, tt=0, match=0 and clear the delay line, including mid-sweep; no sample survives reset.
REQ-022 start asserted in the same cycle as rst SHALL be ignored.

Configuration
REQ-023 Macro TTC_ONES_COUNT_EN SHALL, when defined, add output ones, 8 bits, = population count of tt (0..128), updated with each captured 1 and valid at done; reset and start clear it to 0.
REQ-024 Without TTC_ONES_COUNT_EN the port and its counter SHALL be absent; all other behaviour is identical.

Structure
REQ-025 Package ttc_pkg SHALL hold N_IN=7, TT_W=128, the state enum type, and the sweep-counter width.
REQ-026 The delay line SHALL be a sub-module ttc_sample_delay (parameter depth, carries valid + 7-bit index).

Verification
REQ-027 f_in = maj(x0,x1,x2), SAMPLE_LAT=0, expected=0xE8 repeated 16 times -> tt=0xE8E8...E8, match=1, done in cycle 129.
REQ-028 f_in = x6 registered once, SAMPLE_LAT=1 -> tt = 0xFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0000, done in cycle 130; with TTC_ONES_COUNT_EN, ones=64.
REQ-029 f_in = 0, expected = 0 except bit 0 set -> tt=0, match=0; ones=0 if enabled.
REQ-030 rst asserted at x=60 mid-sweep, then start -> all outputs cleared, fresh sweep begins at x=0, correct tt, no residue from the aborted pass.
REQ-031 start held high for 300 cycles -> back-to-back sweeps, each done spaced 130+SAMPLE_LAT cycles apart, no start accepted while busy.

Source files
------------

// File: rtl/ttc_pkg.sv
// Shared constants and state type for the truth-table capture block.
package ttc_pkg;
  localparam int N_IN  = 7;
  localparam int TT_W  = 128;
  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TT_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } ttc_state_e;
endpackage

// File: rtl/ttc_sample_delay.sv
// Valid/index delay line aligning each driven vector with its f_in sample; DEPTH=0 is a wire.
module ttc_sample_delay
  import ttc_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [N_IN-1:0] in_idx,
  output logic            out_valid,
  output logic [N_IN-1:0] out_idx
);

  if (DEPTH == 0) begin : g_bypass
    logic unused_clk_rst;
    assign unused_clk_rst = clk | rst;
    assign out_valid      = in_valid;
    assign out_idx        = in_idx;
  end else begin : g_pipe
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [N_IN-1:0]  idx_q [DEPTH];
    logic [N_IN-1:0]  idx_d [DEPTH];

    always_comb begin
      vld_d[0] = in_valid;
      idx_d[0] = in_idx;
      for (int i = 1; i < DEPTH; i++) begin
        vld_d[i] = vld_q[i-1];
        idx_d[i] = idx_q[i-1];
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q <= '0;
        for (int i = 0; i < DEPTH; i++) idx_q[i] <= '0;
      end else begin
        vld_q <= vld_d;
        idx_q <= idx_d;
      end
    end

    assign out_valid = vld_q[DEPTH-1];
    assign out_idx   = idx_q[DEPTH-1];
  end

endmodule

// File: rtl/truth_table_capture.sv
// Sweeps x over 0..127, captures f_in into tt and compares against expected.
// Optional TTC_ONES_COUNT_EN adds the 'ones' population-count output.
//
// state | meaning
// IDLE  | waiting for start; x=0, tt/match hold last result
// SWEEP | driving x=0..127, one vector per cycle
// DRAIN | SAMPLE_LAT cycles for in-flight samples to land
// FIN   | done pulse; tt/match/ones final
module truth_table_capture
  import ttc_pkg::*;
#(
  parameter int SAMPLE_LAT = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [TT_W-1:0] expected,
  output logic [N_IN-1:0] x,
  input  logic            f_in,
  output logic            busy,
  output logic            done,
  output logic [TT_W-1:0] tt,
  output logic            match
`ifdef TTC_ONES_COUNT_EN
  ,
  output logic [7:0]      ones
`endif
);

  localparam int DRAIN_W = (SAMPLE_LAT < 2) ? 1 : $clog2(SAMPLE_LAT);
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(SAMPLE_LAT - 1);

  ttc_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [TT_W-1:0]    tt_q, tt_d;
  logic               match_q, match_d;
`ifdef TTC_ONES_COUNT_EN
  logic [7:0]         ones_q, ones_d;
`endif

  logic               smp_vld;
  logic [N_IN-1:0]    smp_idx;

  ttc_sample_delay #(
    .DEPTH(SAMPLE_LAT)
  ) u_delay (
    .clk      (clk),
    .rst      (rst),
    .in_valid (state_q == ST_SWEEP),
    .in_idx   (cnt_q[N_IN-1:0]),
    .out_valid(smp_vld),
    .out_idx  (smp_idx)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    tt_d    = tt_q;
    match_d = match_q;
`ifdef TTC_ONES_COUNT_EN
    ones_d  = ones_q;
`endif

    if (smp_vld) begin
      tt_d[smp_idx] = f_in;
`ifdef TTC_ONES_COUNT_EN
      ones_d = ones_q + {7'd0, f_in};
`endif
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SWEEP;
          cnt_d   = '0;
          busy_d  = 1'b1;
          tt_d    = '0;
          match_d = 1'b0;
`ifdef TTC_ONES_COUNT_EN
          ones_d  = '0;
`endif
        end
      end
      ST_SWEEP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (SAMPLE_LAT == 0) begin
            state_d = ST_FIN;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            match_d = (tt_d == expected);
          end else begin
            state_d = ST_DRAIN;
            drain_d = DRAIN_LOAD;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (drain_q == '0) begin
          state_d = ST_FIN;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          match_d = (tt_d == expected);
        end else begin
          drain_d = drain_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      drain_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tt_q    <= '0;
      match_q <= 1'b0;
`ifdef TTC_ONES_COUNT_EN
      ones_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      tt_q    <= tt_d;
      match_q <= match_d;
`ifdef TTC_ONES_COUNT_EN
      ones_q  <= ones_d;
`endif
    end
  end

  assign x     = cnt_q[N_IN-1:0];
  assign busy  = busy_q;
  assign done  = done_q;
  assign tt    = tt_q;
  assign match = match_q;
`ifdef TTC_ONES_COUNT_EN
  assign ones  = ones_q;
`endif

endmodule

// File: tb/tb_truth_table_capture.sv
// Scoreboard bench for truth_table_capture with SAMPLE_LAT=1 (f_in is lut[x] registered once).
module tb_truth_table_capture;
  localparam int LAT = 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [127:0] expected = '0;
  logic [6:0]   x;
  logic         f_in = 1'b0;
  logic         busy, done, match;
  logic [127:0] tt;
`ifdef TTC_ONES_COUNT_EN
  logic [7:0]   ones;
`endif

  truth_table_capture #(.SAMPLE_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .expected(expected), .x(x),
    .f_in(f_in), .busy(busy), .done(done), .tt(tt), .match(match)
`ifdef TTC_ONES_COUNT_EN
    , .ones(ones)
`endif
  );

  always #5 clk = ~clk;

  // Function under test: a lookup table, registered once to model SAMPLE_LAT=1.
  logic [127:0] lut = '0;
  always @(posedge clk) f_in <= lut[x];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [127:0] tt;
    logic         match;
    logic [7:0]   ones;
    int           dcyc;
  } exp_t;

  exp_t         exp_q[$];
  int           total = 0;
  int           bad = 0;
  int           sweep_s = -1000;
  int           free_cyc = 0;
  logic         hold_valid = 1'b0;
  logic [127:0] hold_tt;
  logic         hold_match;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h want %h", nm, cyc, act, exp);
    end
  endtask

  // Drive one cycle; the acceptance model follows the block's rules, not its state.
  task automatic tick(input logic s, input logic r);
    exp_t e;
    start = s;
    rst   = r;
    if (r) begin
      exp_q.delete();
      sweep_s    = -1000;
      free_cyc   = cyc + 1;
      hold_valid = 1'b0;
    end else if (s && cyc >= free_cyc) begin
      e.tt    = lut;
      e.match = (lut == expected);
      e.ones  = 8'($countones(lut));
      e.dcyc  = cyc + 129 + LAT;
      exp_q.push_back(e);
      sweep_s    = cyc;
      free_cyc   = cyc + 130 + LAT;
      hold_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      tick(1'b0, 1'b0);
      n++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout: pending=%0d want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic run_sweep();
    while (cyc < free_cyc) tick(1'b0, 1'b0);
    repeat ($urandom_range(0, 3)) tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    wait_drain();
  endtask

  // Monitor: per-cycle x/busy model plus scoreboard pop on done.
  always @(negedge clk) begin
    logic [6:0] ex_x;
    logic       ex_busy;
    exp_t       e;
    if (!rst) begin
      ex_x    = (cyc >= sweep_s + 1 && cyc <= sweep_s + 128) ? 7'(cyc - sweep_s - 1) : 7'd0;
      ex_busy = (cyc >= sweep_s + 1 && cyc <= sweep_s + 128 + LAT);
      chk("x", 128'(x), 128'(ex_x));
      chk("busy", 128'(busy), 128'(ex_busy));
      if (exp_q.size() != 0 && exp_q[0].dcyc < cyc) begin
        total++;
        bad++;
        $display("FAIL missing_done: expected done at cycle %0d, now %0d", exp_q[0].dcyc, cyc);
        void'(exp_q.pop_front());
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done at cycle %0d: got 1 want 0", cyc);
        end else begin
          e = exp_q.pop_front();
          chk("done_cycle", 128'(cyc), 128'(e.dcyc));
          chk("tt", tt, e.tt);
          chk("match", 128'(match), 128'(e.match));
`ifdef TTC_ONES_COUNT_EN
          chk("ones", 128'(ones), 128'(e.ones));
`endif
          hold_valid = 1'b1;
          hold_tt    = e.tt;
          hold_match = e.match;
        end
      end else if (hold_valid) begin
        chk("tt_hold", tt, hold_tt);
        chk("match_hold", 128'(match), 128'(hold_match));
      end
    end
  end

  initial begin
    int s;
    // Reset with start asserted alongside: start must be ignored.
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    tick(1'b0, 1'b0);
    chk("rst_x", 128'(x), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_done", 128'(done), 128'd0);
    chk("rst_tt", tt, 128'd0);
    chk("rst_match", 128'(match), 128'd0);
`ifdef TTC_ONES_COUNT_EN
    chk("rst_ones", 128'(ones), 128'd0);
`endif
    repeat (5) tick(1'b0, 1'b0);

    // Majority of x0..x2 against the published 0xE8 pattern.
    for (int i = 0; i < 128; i++) lut[i] = ((i & 1) + ((i >> 1) & 1) + ((i >> 2) & 1)) >= 2;
    expected = {16{8'hE8}};
    run_sweep();

    // f = x6: upper half ones.
    for (int i = 0; i < 128; i++) lut[i] = (i >= 64);
    expected = 128'hFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0000;
    run_sweep();

    // Constant zero against a table with bit 0 set: mismatch.
    lut = '0;
    expected = 128'd1;
    run_sweep();

    // Random functions, expected sometimes equal, sometimes one bit off.
    for (int n = 0; n < 4; n++) begin
      lut = {$urandom, $urandom, $urandom, $urandom};
      expected = lut;
      if (n[0]) expected[$urandom_range(0, 127)] ^= 1'b1;
      run_sweep();
    end

    // Reset mid-sweep while x=60, then a fresh sweep with a different function.
    lut = {$urandom, $urandom, $urandom, $urandom};
    while (cyc < free_cyc) tick(1'b0, 1'b0);
    s = cyc;
    tick(1'b1, 1'b0);
    while (cyc < s + 61) tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    chk("midrst_tt", tt, 128'd0);
    chk("midrst_done", 128'(done), 128'd0);
    chk("midrst_match", 128'(match), 128'd0);
    lut = ~lut;
    expected = lut;
    run_sweep();

    // start held high for 300 cycles: back-to-back sweeps.
    lut = {$urandom, $urandom, $urandom, $urandom};
    expected = lut;
    repeat (300) tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    wait_drain();
    repeat (4) tick(1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
